// File: rtl/mem_write_gen.sv
// Scatters an input beat stream across N_BANKS write ports, one address per bank group.
// The group address walks column-major (stride R) or linear, selected when the transfer starts.
module mem_write_gen #(
  parameter int N_BANKS = 4,
  parameter int DATA_W  = 32,
  parameter int DIM_W   = 16,
  parameter int ADDR_W  = 12
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_start,
  input  logic [DIM_W-1:0]    i_cfg_rows,
  input  logic [DIM_W-1:0]    i_cfg_cols,
  input  logic                i_cfg_mode,
  input  logic                i_abort,
  input  logic                i_in_valid,
  output logic                o_in_ready,
  input  logic [DATA_W-1:0]   i_in_data,
  output logic [N_BANKS-1:0]  o_wr_en,
  output logic [ADDR_W-1:0]   o_wr_addr,
  output logic [DATA_W-1:0]   o_wr_data,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_cfg_err
);

  localparam int BANK_W = $clog2(N_BANKS);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]          r_state;
  logic [DIM_W-1:0]    r_rows;
  logic [DIM_W-1:0]    r_cols;
  logic                r_mode;
  logic [BANK_W-1:0]   r_bank;
  logic [DIM_W-1:0]    r_col;
  logic [ADDR_W-1:0]   r_addr;
  logic [ADDR_W-1:0]   r_base;
  logic [ADDR_W-1:0]   r_grp;
  logic [ADDR_W-1:0]   r_last_grp;
  logic [N_BANKS-1:0]  r_wr_en;
  logic [ADDR_W-1:0]   r_wr_addr;
  logic [DATA_W-1:0]   r_wr_data;
  logic                r_cfg_err;

  logic [2*DIM_W-1:0]  w_prod;
  logic [2*DIM_W-1:0]  w_prod_m1;
  logic                w_cfg_ok;
  logic                w_accept;
  logic                w_last_bank;
  logic                w_last_beat;
  logic [N_BANKS-1:0]  w_strobe;

  // R*C-1 fits in ADDR_W bits exactly when 1 <= R*C <= 2^ADDR_W
  assign w_prod      = {{DIM_W{1'b0}}, i_cfg_rows} * {{DIM_W{1'b0}}, i_cfg_cols};
  assign w_prod_m1   = w_prod - (2*DIM_W)'(1);
  assign w_cfg_ok    = (i_cfg_rows != '0) && (i_cfg_cols != '0) && ((w_prod_m1 >> ADDR_W) == '0);

  assign w_accept    = i_in_valid && (r_state == S_RUN);
  assign w_last_bank = (r_bank == BANK_W'(N_BANKS - 1));
  assign w_last_beat = w_accept && w_last_bank && (r_grp == r_last_grp);

  for (genvar b = 0; b < N_BANKS; b++) begin : g_strobe
    assign w_strobe[b] = w_accept && (r_bank == BANK_W'(b));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_rows     <= '0;
      r_cols     <= '0;
      r_mode     <= 1'b0;
      r_bank     <= '0;
      r_col      <= '0;
      r_addr     <= '0;
      r_base     <= '0;
      r_grp      <= '0;
      r_last_grp <= '0;
      r_wr_en    <= '0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
      r_cfg_err  <= 1'b0;
    end else begin
      r_cfg_err <= 1'b0;
      r_wr_en   <= w_strobe;
      if (w_accept) begin
        r_wr_addr <= r_addr;
        r_wr_data <= i_in_data;
      end
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            if (w_cfg_ok) begin
              r_rows     <= i_cfg_rows;
              r_cols     <= i_cfg_cols;
              r_mode     <= i_cfg_mode;
              r_last_grp <= ADDR_W'(w_prod_m1);
              r_bank     <= '0;
              r_col      <= '0;
              r_addr     <= '0;
              r_base     <= '0;
              r_grp      <= '0;
              r_state    <= S_RUN;
            end else begin
              r_cfg_err  <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (w_accept) begin
            if (w_last_bank) begin
              r_bank <= '0;
              r_grp  <= r_grp + ADDR_W'(1);
              if (r_mode) begin
                r_addr <= r_addr + ADDR_W'(1);
              end else if (r_col != r_cols - DIM_W'(1)) begin
                // step down the column by the row stride
                r_addr <= r_addr + ADDR_W'(r_rows);
                r_col  <= r_col + DIM_W'(1);
              end else begin
                r_col  <= '0;
                r_base <= r_base + ADDR_W'(1);
                r_addr <= r_base + ADDR_W'(1);
              end
            end else begin
              r_bank <= r_bank + BANK_W'(1);
            end
          end
          if (i_abort)          r_state <= S_IDLE;
          else if (w_last_beat) r_state <= S_DONE;
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_in_ready = (r_state == S_RUN);
  assign o_busy     = (r_state == S_RUN);
  assign o_done     = (r_state == S_DONE);
  assign o_wr_en    = r_wr_en;
  assign o_wr_addr  = r_wr_addr;
  assign o_wr_data  = r_wr_data;
  assign o_cfg_err  = r_cfg_err;

endmodule

// File: tb/tb_mem_write_gen.sv
// Directed bench for mem_write_gen: config-reject table plus multi-cycle transfer sequences
// with hand-listed group address orders for R=2, C=3, four banks.
module tb_mem_write_gen;
  localparam int NB = 4;
  localparam int DW = 32;
  localparam int DMW = 16;
  localparam int AW = 12;
  localparam int NBEATS = NB * 6;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           i_start = 1'b0;
  logic [DMW-1:0] i_cfg_rows = '0;
  logic [DMW-1:0] i_cfg_cols = '0;
  logic           i_cfg_mode = 1'b0;
  logic           i_abort = 1'b0;
  logic           i_in_valid = 1'b0;
  logic           o_in_ready;
  logic [DW-1:0]  i_in_data = '0;
  logic [NB-1:0]  o_wr_en;
  logic [AW-1:0]  o_wr_addr;
  logic [DW-1:0]  o_wr_data;
  logic           o_busy, o_done, o_cfg_err;

  mem_write_gen #(.N_BANKS(NB), .DATA_W(DW), .DIM_W(DMW), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_cfg_rows(i_cfg_rows), .i_cfg_cols(i_cfg_cols),
    .i_cfg_mode(i_cfg_mode), .i_abort(i_abort), .i_in_valid(i_in_valid), .o_in_ready(o_in_ready),
    .i_in_data(i_in_data), .o_wr_en(o_wr_en), .o_wr_addr(o_wr_addr), .o_wr_data(o_wr_data),
    .o_busy(o_busy), .o_done(o_done), .o_cfg_err(o_cfg_err));

  always #5 clk = ~clk;

  typedef struct {
    logic [DMW-1:0] rows;
    logic [DMW-1:0] cols;
    logic           mode;
    logic           exp_err;
  } cfg_vec_t;

  cfg_vec_t    cv[6];
  logic [AW-1:0] ea0[6];
  logic [AW-1:0] ea1[6];
  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, "_wr_en"}, 64'(o_wr_en), 64'd0);
    chk({tag, "_busy"}, 64'(o_busy), 64'd0);
    chk({tag, "_done"}, 64'(o_done), 64'd0);
    chk({tag, "_ready"}, 64'(o_in_ready), 64'd0);
  endtask

  // Called on a negedge; starts R=2,C=3 and streams beats, checking every cycle.
  task automatic do_xfer(input logic mode, input int gap, input int abort_at,
                         input int junk_at, input logic [DW-1:0] tag);
    bit run, acc, ab;
    int e, ep;
    logic [AW-1:0] ea;
    i_cfg_rows = 16'd2; i_cfg_cols = 16'd3; i_cfg_mode = mode; i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    i_cfg_rows = 16'd9; i_cfg_cols = 16'd9; i_cfg_mode = ~mode;
    run = 1'b1; acc = 1'b0; ab = 1'b0; e = 0; ep = 0;
    for (int cyc = 0; cyc < 500; cyc++) begin
      if (acc) begin
        ea = mode ? ea1[ep / NB] : ea0[ep / NB];
        chk("wr_en", 64'(o_wr_en), 64'(1) << (ep % NB));
        chk("wr_addr", 64'(o_wr_addr), 64'(ea));
        chk("wr_data", 64'(o_wr_data), 64'(tag + DW'(ep)));
        chk("done", 64'(o_done), 64'((ep == NBEATS - 1) && !ab));
      end else begin
        chk("gap_wr_en", 64'(o_wr_en), 64'd0);
        chk("gap_done", 64'(o_done), 64'd0);
      end
      chk("ready", 64'(o_in_ready), 64'(run));
      chk("busy", 64'(o_busy), 64'(run));
      chk("cfg_err", 64'(o_cfg_err), 64'd0);
      if (!run) break;
      i_in_valid = ($urandom_range(99) >= gap);
      i_in_data  = tag + DW'(e);
      i_abort    = (abort_at == e + 1) && i_in_valid;
      i_start    = (junk_at > 0) && (e == junk_at);
      acc = i_in_valid; ep = e; ab = i_abort;
      if (acc) begin
        e++;
        if (i_abort || e == NBEATS) run = 1'b0;
      end
      @(negedge clk);
    end
    chk("xfer_timeout", 64'(run), 64'd0);
    i_in_valid = 1'b0; i_abort = 1'b0; i_start = 1'b0;
    @(negedge clk);
    chk_idle_zero("post");
  endtask

  initial begin
    cv[0] = '{rows: 16'd0,    cols: 16'd3,    mode: 1'b0, exp_err: 1'b1};
    cv[1] = '{rows: 16'd2,    cols: 16'd0,    mode: 1'b0, exp_err: 1'b1};
    cv[2] = '{rows: 16'd256,  cols: 16'd256,  mode: 1'b0, exp_err: 1'b1};
    cv[3] = '{rows: 16'd64,   cols: 16'd64,   mode: 1'b0, exp_err: 1'b0};
    cv[4] = '{rows: 16'd4097, cols: 16'd1,    mode: 1'b1, exp_err: 1'b1};
    cv[5] = '{rows: 16'd1,    cols: 16'd4096, mode: 1'b1, exp_err: 1'b0};
    ea0 = '{12'd0, 12'd2, 12'd4, 12'd1, 12'd3, 12'd5};
    ea1 = '{12'd0, 12'd1, 12'd2, 12'd3, 12'd4, 12'd5};

    // reset state, with a valid start held during reset
    i_cfg_rows = 16'd2; i_cfg_cols = 16'd3; i_start = 1'b1;
    repeat (3) @(negedge clk);
    chk_idle_zero("rst");
    chk("rst_addr", 64'(o_wr_addr), 64'd0);
    chk("rst_data", 64'(o_wr_data), 64'd0);
    chk("rst_cfg_err", 64'(o_cfg_err), 64'd0);
    i_start = 1'b0;

    rst = 1'b0;
    do_xfer(1'b0, 0, 0, 0, 32'hA000_0000);
    do_xfer(1'b1, 0, 0, 0, 32'hB000_0000);
    do_xfer(1'b0, 50, 0, 5, 32'hC000_0000);
    do_xfer(1'b0, 0, 10, 0, 32'hD000_0000);
    do_xfer(1'b0, 0, 0, 0, 32'hE000_0000);

    for (int i = 0; i < 6; i++) begin
      i_cfg_rows = cv[i].rows; i_cfg_cols = cv[i].cols; i_cfg_mode = cv[i].mode;
      i_start = 1'b1;
      @(negedge clk);
      i_start = 1'b0;
      chk($sformatf("cfg%0d_err", i), 64'(o_cfg_err), 64'(cv[i].exp_err));
      chk($sformatf("cfg%0d_busy", i), 64'(o_busy), 64'(!cv[i].exp_err));
      if (!cv[i].exp_err) i_abort = 1'b1;
      @(negedge clk);
      i_abort = 1'b0;
      chk($sformatf("cfg%0d_err_end", i), 64'(o_cfg_err), 64'd0);
      chk($sformatf("cfg%0d_busy_end", i), 64'(o_busy), 64'd0);
      chk($sformatf("cfg%0d_done", i), 64'(o_done), 64'd0);
    end

    // reset mid-transfer with start and valid both high
    i_cfg_rows = 16'd2; i_cfg_cols = 16'd3; i_cfg_mode = 1'b0; i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0; i_in_valid = 1'b1; i_in_data = 32'h1234_5678;
    repeat (7) @(negedge clk);
    chk("mid_busy", 64'(o_busy), 64'd1);
    rst = 1'b1; i_start = 1'b1;
    @(negedge clk);
    chk_idle_zero("midrst");
    chk("midrst_addr", 64'(o_wr_addr), 64'd0);
    chk("midrst_data", 64'(o_wr_data), 64'd0);
    chk("midrst_cfg_err", 64'(o_cfg_err), 64'd0);
    rst = 1'b0; i_start = 1'b0; i_in_valid = 1'b0;
    do_xfer(1'b1, 30, 0, 3, 32'hF000_0000);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/mem_write_gen.md
MEM_WRITE_GEN -- requirements
Module: mem_write_gen

Interface
REQ-001 Parameter N_BANKS, default 4, number of destination banks (>= 2).
REQ-002 Parameter DATA_W, default 32, data beat width.
REQ-003 Parameter DIM_W, default 16, width of dimension inputs.
REQ-004 Parameter ADDR_W, default 12, per-bank write address width.
REQ-005 clk  in  1  clock; all logic is rising-edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 start  in  1  pulse; latches the cfg_* inputs and begins a transfer.
REQ-008 cfg_rows  in  DIM_W  R, stride in column mode (matrix rows).
REQ-009 cfg_cols  in  DIM_W  C, columns per bank.
REQ-010 cfg_mode  in  1  0 = column-major strided, 1 = linear.
REQ-011 abort  in  1  terminates the current transfer.
REQ-012 in_valid / in_ready / in_data  in / out / in  1 / 1 / DATA_W  input beat stream.
REQ-013 wr_en  out  N_BANKS  one-hot bank write strobe.
REQ-014 wr_addr / wr_data  out  ADDR_W / DATA_W  write address and data for the strobed bank.
REQ-015 busy / done / cfg_err  out  1 each  running flag, completion pulse, config-reject pulse.

Function
REQ-016 The block SHALL implement the states IDLE, RUN and DONE.
REQ-017 IDLE: start with R != 0, C != 0 and R*C <= 2^ADDR_W (full 2*DIM_W-bit product) SHALL latch R, C and mode, clear all counters, and enter RUN.
REQ-018 IDLE: start with an invalid configuration SHALL pulse cfg_err for one cycle and remain in IDLE.
REQ-019 in_ready SHALL equal (state == RUN) and SHALL be combinational from state only; busy SHALL equal (state == RUN).
REQ-020 A beat is accepted when in_valid && in_ready; output latency SHALL be 1 cycle, with wr_en, wr_addr and wr_data registered and wr_en all-zero in cycles without an accepted beat.
REQ-021 Accepted beat index e SHALL map to bank b = e mod N_BANKS (wr_en = 1 << b) and group g = e div N_BANKS; each group SHALL use one address across banks 0..N_BANKS-1 in ascending order.
REQ-022 Mode 0: group address SHALL be (g mod C)*R + (g div C), generated incrementally without a multiplier: after the last bank, if column k < C-1 then addr += R and k++; otherwise k = 0, base++ and addr = base.
REQ-023 Mode 1: group address SHALL be g (addr++ after the last bank).
REQ-024 Transfer length SHALL be R*C*N_BANKS beats; acceptance of the final beat SHALL move the block to DONE, and in_ready SHALL be low from the next cycle.
REQ-025 DONE SHALL last exactly one cycle with done = 1, coincident with the final write strobe, then return to IDLE.
REQ-026 start while in RUN or DONE SHALL be ignored; no cfg_err SHALL be generated.
REQ-027 abort in RUN SHALL move the block to IDLE on the next edge without a done pulse; a beat accepted in the same cycle SHALL still be written; abort takes priority over a final-beat DONE transition.
REQ-028 Latched configuration SHALL NOT change during RUN regardless of the cfg_* inputs.
REQ-029 Arithmetic SHALL be unsigned; address registers SHALL be ADDR_W bits and, given REQ-017, SHALL never wrap within a valid transfer.

Reset
REQ-030 rst SHALL take priority over all inputs, including mid-transfer.
REQ-031 Reset SHALL force IDLE; wr_en = 0, wr_addr = 0, wr_data = 0, busy = 0, done = 0, cfg_err = 0; counters and latched config = 0.
REQ-032 The first start is accepted in the cycle after rst deasserts.

Verification
REQ-033 N_BANKS=4, R=2, C=3, mode 0, in_valid held high -> 24 writes; group addresses 0,2,4,1,3,5; each group strobes wr_en 0001,0010,0100,1000; done coincides with the 24th write.
REQ-034 Same config, mode 1 -> group addresses 0..5 in order; 24 writes; single done pulse.
REQ-035 start with R=0, then with C=0, then with R=C=256 at ADDR_W=12 -> one cfg_err pulse each; busy remains 0.
REQ-036 Random in_valid gaps (50%) in the REQ-033 config -> identical address/bank sequence; wr_en = 0 in gap cycles.
REQ-037 abort after 10 beats -> the 10th beat is written; IDLE next cycle; no done; a following start runs a full clean transfer from address 0.
REQ-038 rst asserted mid-transfer, and start asserted during RUN -> all outputs at reset values the next cycle; the ignored start leaves the sequence unchanged.
